// File: rtl/mult_rr_scheduler.sv
// Round-robin front end sharing one combinational multiplier among NUM_REQ requesters.
// Two registered stages (operands, product), each with valid/ready backpressure.
module mult_rr_scheduler_mul #(
    parameter int A_BIT   = 16,
    parameter int B_BIT   = 8,
    parameter int OUT_BIT = 32
) (
    input  logic [A_BIT-1:0]   a,
    input  logic [B_BIT-1:0]   b,
    output logic [OUT_BIT-1:0] m
);
    logic [A_BIT+B_BIT-1:0] p;

    assign p = {{B_BIT{1'b0}}, a} * {{A_BIT{1'b0}}, b};
    assign m = OUT_BIT'(p);
endmodule

module mult_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_BIT  = 2,
    parameter int A_BIT   = 16,
    parameter int B_BIT   = 8,
    parameter int OUT_BIT = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*A_BIT-1:0] req_a,
    input  logic [NUM_REQ*B_BIT-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [ID_BIT-1:0]        rsp_id,
    output logic [OUT_BIT-1:0]       rsp_m,
    input  logic                     rsp_ready,
    output logic                     busy
);
    logic [A_BIT-1:0]   op_a;
    logic [B_BIT-1:0]   op_b;
    logic [ID_BIT-1:0]  op_id;
    logic               op_valid;
    logic [ID_BIT-1:0]  ptr;
    logic [ID_BIT-1:0]  g;
    logic               any;
    logic               adv2;
    logic               s1_free;
    logic               xfer;
    logic [OUT_BIT-1:0] prod;

    assign adv2    = !rsp_valid | rsp_ready;
    assign s1_free = !op_valid | adv2;

    // Scan from the farthest offset down so the first hit after ptr wins last.
    always_comb begin
        logic [ID_BIT-1:0] idx;
        g   = '0;
        any = 1'b0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + ID_BIT'(i);
            if (req_valid[idx]) begin
                g   = idx;
                any = 1'b1;
            end
        end
    end

    // Gated by rstn so no grant is shown while reset is held.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
        assign req_ready[i] = rstn && any && s1_free && (g == ID_BIT'(i));
    end

    assign xfer = |(req_valid & req_ready);
    assign busy = op_valid | rsp_valid;

    mult_rr_scheduler_mul #(
        .A_BIT  (A_BIT),
        .B_BIT  (B_BIT),
        .OUT_BIT(OUT_BIT)
    ) u_mul (
        .a(op_a),
        .b(op_b),
        .m(prod)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            op_valid  <= 1'b0;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_m     <= '0;
        end else begin
            if (xfer) begin
                op_a     <= req_a[g*A_BIT +: A_BIT];
                op_b     <= req_b[g*B_BIT +: B_BIT];
                op_id    <= g;
                op_valid <= 1'b1;
                ptr      <= g + ID_BIT'(1);
            end else if (s1_free) begin
                op_valid <= 1'b0;
            end

            if (adv2) begin
                if (op_valid) begin
                    rsp_m     <= prod;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                end else begin
                    rsp_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler: inputs change on negedge, outputs checked 1ns later.
module tb_mult_rr_scheduler;
    localparam int NUM_REQ = 4;
    localparam int ID_BIT  = 2;
    localparam int A_BIT   = 16;
    localparam int B_BIT   = 8;
    localparam int OUT_BIT = 32;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*A_BIT-1:0] req_a;
    logic [NUM_REQ*B_BIT-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic [ID_BIT-1:0]        rsp_id;
    logic [OUT_BIT-1:0]       rsp_m;
    logic                     rsp_ready;
    logic                     busy;

    int n_cmp = 0;
    int n_err = 0;

    mult_rr_scheduler #(
        .NUM_REQ(NUM_REQ), .ID_BIT(ID_BIT), .A_BIT(A_BIT), .B_BIT(B_BIT), .OUT_BIT(OUT_BIT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_m    (rsp_m),
        .rsp_ready(rsp_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [A_BIT-1:0] a, input logic [B_BIT-1:0] b);
        req_a[i*A_BIT +: A_BIT] = a;
        req_b[i*B_BIT +: B_BIT] = b;
    endtask

    task automatic chk_rsp(input string tag, input logic [ID_BIT-1:0] id, input logic [OUT_BIT-1:0] m);
        chk({tag, "_vld"}, rsp_valid, 1'b1);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_m"}, rsp_m, m);
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_m", rsp_m, 32'h0);
        chk("rst_rsp_id", rsp_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_first_grant", req_ready, 4'b0001);
        req_valid = 4'b0000;

        // full contention: a=i+1, b=i+2
        for (int i = 0; i < NUM_REQ; i++) set_ops(i, A_BIT'(i + 1), B_BIT'(i + 2));
        @(negedge clk);
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            if (c == 6) req_valid = 4'h0;
            #1;
            if (c < 6) chk($sformatf("cont_grant%0d", c), req_ready, 4'b0001 << (c % 4));
            if (c >= 2) chk_rsp($sformatf("cont_rsp%0d", c - 2), ID_BIT'((c - 2) % 4),
                                OUT_BIT'((((c - 2) % 4) + 1) * (((c - 2) % 4) + 2)));
            @(negedge clk);
        end
        #1;
        chk("cont_drain", rsp_valid, 1'b0);

        // single request, ptr=2 so requester 1 still wins (search 2,3,0,1)
        set_ops(1, 16'hFFFF, 8'hFF);
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        chk("single_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("single_lat0_vld", rsp_valid, 1'b0);
        chk("single_busy", busy, 1'b1);
        @(negedge clk); #1;
        chk_rsp("single_rsp", 2'd1, 32'h00FE_FF01);
        @(negedge clk); #1;
        chk("single_after", rsp_valid, 1'b0);
        chk("single_idle", busy, 1'b0);

        // pointer wrap: ptr=2 -> grant 2, ptr=3 -> grant 0, ptr=1 -> grant 2
        set_ops(1, 16'd2, 8'd3);
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        chk("wrap_g2", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'b0101;
        #1;
        chk("wrap_g0", req_ready, 4'b0001);
        @(negedge clk); #1;
        chk("wrap_g2b", req_ready, 4'b0100);
        chk_rsp("wrap_rsp2", 2'd2, 32'd12);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk_rsp("wrap_rsp0", 2'd0, 32'd2);
        @(negedge clk); #1;
        chk_rsp("wrap_rsp2b", 2'd2, 32'd12);
        @(negedge clk); #1;
        chk("wrap_drain", rsp_valid, 1'b0);

        // backpressure: ptr=3 -> grants 0 then 1, then 3 stall cycles
        @(negedge clk);
        req_valid = 4'b0011;
        #1;
        chk("bp_g0", req_ready, 4'b0001);
        @(negedge clk); #1;
        chk("bp_g1", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk_rsp($sformatf("bp_hold%0d", s), 2'd0, 32'd2);
            chk($sformatf("bp_noready%0d", s), req_ready, 4'b0000);
            @(negedge clk);
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        #1;
        chk_rsp("bp_rel0", 2'd0, 32'd2);
        @(negedge clk); #1;
        chk_rsp("bp_rel1", 2'd1, 32'd6);
        @(negedge clk); #1;
        chk("bp_drain", rsp_valid, 1'b0);

        // reset mid-stream with both stages full (ptr=2 -> grants 2, 3)
        @(negedge clk);
        req_valid = 4'b1100;
        rsp_ready = 1'b0;
        #1;
        chk("mrst_g2", req_ready, 4'b0100);
        @(negedge clk); #1;
        chk("mrst_g3", req_ready, 4'b1000);
        @(negedge clk); #1;
        chk("mrst_full_busy", busy, 1'b1);
        chk("mrst_full_ready", req_ready, 4'b0000);
        chk_rsp("mrst_full_rsp", 2'd2, 32'd12);
        #1;
        rstn = 1'b0;
        #1;
        chk("mrst_vld", rsp_valid, 1'b0);
        chk("mrst_m", rsp_m, 32'h0);
        chk("mrst_id", rsp_id, 2'd0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_ready", req_ready, 4'b0000);
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("mrst_nostale%0d", s), rsp_valid, 1'b0);
            @(negedge clk);
        end
        req_valid = 4'hF;
        #1;
        chk("mrst_ptr0", req_ready, 4'b0001);
        req_valid = 4'h0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
